// File: rtl/rs_pkg.sv
// rs_pkg: shared types for the ALU reservation station.
// Entries carry their own operand readiness so wakeup is a pure per-entry update.
package rs_pkg;

    localparam int RS_TAG_W = 4;

    typedef logic [63:0] MemoryWord;
    typedef logic [RS_TAG_W-1:0] RobTag;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT
    } aluop_e;

    typedef struct packed {
        logic   usign;
        aluop_e aluop;
    } control_bits;

    typedef struct packed {
        logic        valid;
        control_bits ctrl;
        RobTag       rob_tag;
        logic        a_rdy;
        RobTag       a_tag;
        MemoryWord   a_val;
        logic        b_rdy;
        RobTag       b_tag;
        MemoryWord   b_val;
    } rs_entry;

    // Capture a CDB broadcast into whichever pending operands are waiting on its tag.
    function automatic rs_entry rs_wake(rs_entry e, logic v, RobTag t, MemoryWord d);
        rs_entry r;
        r = e;
        if (v && e.valid && !e.a_rdy && e.a_tag == t) begin
            r.a_rdy = 1'b1;
            r.a_val = d;
        end
        if (v && e.valid && !e.b_rdy && e.b_tag == t) begin
            r.b_rdy = 1'b1;
            r.b_val = d;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_reservation_station_select.sv
// rs_oldest_select: combinational priority picker returning the lowest ready index.
module rs_oldest_select #(
    parameter int DEPTH = 4,
    localparam int IW = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] ready_i,
    output logic             found_o,
    output logic [IW-1:0]    idx_o
);

    always_comb begin
        idx_o = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (ready_i[i]) idx_o = IW'(i);
    end

    assign found_o = |ready_i;

endmodule

// File: rtl/alu_reservation_station.sv
// alu_reservation_station: compacting out-of-order issue queue feeding the ALU.
// Index 0 is always the oldest entry; removal shifts younger entries down in the same edge.
module alu_reservation_station
    import rs_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = RS_TAG_W,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int IW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             disp_valid_i,
    output logic             disp_ready_o,
    input  control_bits      disp_ctrl_i,
    input  logic [TAG_W-1:0] disp_rob_tag_i,
    input  logic             disp_a_rdy_i,
    input  logic [TAG_W-1:0] disp_a_tag_i,
    input  logic [63:0]      disp_a_val_i,
    input  logic             disp_b_rdy_i,
    input  logic [TAG_W-1:0] disp_b_tag_i,
    input  logic [63:0]      disp_b_val_i,
    input  logic             cdb_valid_i,
    input  logic [TAG_W-1:0] cdb_tag_i,
    input  logic [63:0]      cdb_val_i,
    output logic             iss_valid_o,
    input  logic             iss_ready_i,
    output control_bits      iss_ctrl_o,
    output logic [63:0]      iss_a_o,
    output logic [63:0]      iss_b_o,
    output logic [TAG_W-1:0] iss_rob_tag_o,
    output logic [CW-1:0]    count_o
);

    rs_entry          ent_q [DEPTH];
    rs_entry          ent_d [DEPTH];
    rs_entry          sh    [DEPTH];
    rs_entry          nw;
    logic [CW-1:0]    cnt_q, cnt_d, pc;
    logic [DEPTH-1:0] cand;
    logic [IW-1:0]    sel;
    logic             found, load, accept;
    logic             iss_valid_q;
    control_bits      iss_ctrl_q;
    MemoryWord        iss_a_q, iss_b_q;
    RobTag            iss_tag_q;

    always_comb begin
        cand = '0;
        for (int i = 0; i < DEPTH; i++)
            cand[i] = ent_q[i].valid && ent_q[i].a_rdy && ent_q[i].b_rdy;
    end

    rs_oldest_select #(.DEPTH(DEPTH)) u_sel (
        .ready_i (cand),
        .found_o (found),
        .idx_o   (sel)
    );

    assign disp_ready_o = cnt_q < CW'(DEPTH);
    assign accept       = disp_valid_i && disp_ready_o;
    assign load         = (!iss_valid_q || iss_ready_i) && found;
    assign pc           = cnt_q - CW'(load);
    assign cnt_d        = flush_i ? '0 : cnt_q + CW'(accept) - CW'(load);

    // A dispatched op sees the same-cycle broadcast so it never misses its producer.
    always_comb begin
        nw = '{valid: 1'b1, ctrl: disp_ctrl_i, rob_tag: disp_rob_tag_i,
               a_rdy: disp_a_rdy_i, a_tag: disp_a_tag_i, a_val: disp_a_val_i,
               b_rdy: disp_b_rdy_i, b_tag: disp_b_tag_i, b_val: disp_b_val_i};
        nw = rs_wake(nw, cdb_valid_i, cdb_tag_i, cdb_val_i);
    end

    always_comb begin
        sh = ent_q;
        for (int i = 0; i < DEPTH - 1; i++)
            if (load && i >= int'(sel)) sh[i] = ent_q[i + 1];
        if (load) sh[DEPTH - 1] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = (accept && i == int'(pc)) ? nw : rs_wake(sh[i], cdb_valid_i, cdb_tag_i, cdb_val_i);
            if (flush_i) ent_d[i] = '0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ent_q       <= '{default: '0};
            cnt_q       <= '0;
            iss_valid_q <= 1'b0;
            iss_ctrl_q  <= '0;
            iss_a_q     <= '0;
            iss_b_q     <= '0;
            iss_tag_q   <= '0;
        end else begin
            ent_q <= ent_d;
            cnt_q <= cnt_d;
            if (flush_i) begin
                iss_valid_q <= 1'b0;
            end else if (load) begin
                iss_valid_q <= 1'b1;
                iss_ctrl_q  <= ent_q[sel].ctrl;
                iss_a_q     <= ent_q[sel].a_val;
                iss_b_q     <= ent_q[sel].b_val;
                iss_tag_q   <= ent_q[sel].rob_tag;
            end else if (iss_ready_i) begin
                iss_valid_q <= 1'b0;
            end
        end
    end

    assign iss_valid_o   = iss_valid_q;
    assign iss_ctrl_o    = iss_ctrl_q;
    assign iss_a_o       = iss_a_q;
    assign iss_b_o       = iss_b_q;
    assign iss_rob_tag_o = iss_tag_q;
    assign count_o       = cnt_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// tb_alu_reservation_station: directed scenarios plus random traffic checked against a queue model.
module tb_alu_reservation_station;
    import rs_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, flush, disp_valid, disp_ready, disp_a_rdy, disp_b_rdy;
    logic        cdb_valid, iss_valid, iss_ready;
    control_bits disp_ctrl, iss_ctrl;
    RobTag       disp_rob_tag, disp_a_tag, disp_b_tag, cdb_tag, iss_rob_tag;
    MemoryWord   disp_a_val, disp_b_val, cdb_val, iss_a, iss_b;
    logic [2:0]  count;

    int total = 0;
    int bad = 0;

    rs_entry mq[$];
    logic    m_iv;
    rs_entry m_iss;

    alu_reservation_station #(.DEPTH(DEPTH), .TAG_W(4)) dut (
        .clk_i(clk), .reset_i(reset), .flush_i(flush),
        .disp_valid_i(disp_valid), .disp_ready_o(disp_ready), .disp_ctrl_i(disp_ctrl),
        .disp_rob_tag_i(disp_rob_tag),
        .disp_a_rdy_i(disp_a_rdy), .disp_a_tag_i(disp_a_tag), .disp_a_val_i(disp_a_val),
        .disp_b_rdy_i(disp_b_rdy), .disp_b_tag_i(disp_b_tag), .disp_b_val_i(disp_b_val),
        .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_val_i(cdb_val),
        .iss_valid_o(iss_valid), .iss_ready_i(iss_ready), .iss_ctrl_o(iss_ctrl),
        .iss_a_o(iss_a), .iss_b_o(iss_b), .iss_rob_tag_o(iss_rob_tag), .count_o(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_iv  = 1'b0;
        m_iss = '0;
    endtask

    // Queue model: oldest-first list, pick first fully-ready op, wake the rest, append dispatch.
    task automatic model_step();
        int k;
        bit acc;
        rs_entry e;
        if (flush) begin
            mq.delete();
            m_iv = 1'b0;
            return;
        end
        acc = disp_valid && (mq.size() < DEPTH);
        k = -1;
        foreach (mq[i]) if (k < 0 && mq[i].a_rdy && mq[i].b_rdy) k = i;
        if ((!m_iv || iss_ready) && k >= 0) begin
            m_iss = mq[k];
            mq.delete(k);
            m_iv = 1'b1;
        end else if (iss_ready) begin
            m_iv = 1'b0;
        end
        foreach (mq[i]) begin
            if (cdb_valid && !mq[i].a_rdy && mq[i].a_tag == cdb_tag) begin
                mq[i].a_rdy = 1'b1;
                mq[i].a_val = cdb_val;
            end
            if (cdb_valid && !mq[i].b_rdy && mq[i].b_tag == cdb_tag) begin
                mq[i].b_rdy = 1'b1;
                mq[i].b_val = cdb_val;
            end
        end
        if (acc) begin
            e = '0;
            e.valid = 1'b1;
            e.ctrl = disp_ctrl;
            e.rob_tag = disp_rob_tag;
            e.a_rdy = disp_a_rdy || (cdb_valid && cdb_tag == disp_a_tag);
            e.a_tag = disp_a_tag;
            e.a_val = disp_a_rdy ? disp_a_val : (e.a_rdy ? cdb_val : disp_a_val);
            e.b_rdy = disp_b_rdy || (cdb_valid && cdb_tag == disp_b_tag);
            e.b_tag = disp_b_tag;
            e.b_val = disp_b_rdy ? disp_b_val : (e.b_rdy ? cdb_val : disp_b_val);
            mq.push_back(e);
        end
    endtask

    task automatic compare_all();
        chk("disp_ready", disp_ready, mq.size() < DEPTH);
        chk("count", count, mq.size());
        chk("iss_valid", iss_valid, m_iv);
        if (m_iv) begin
            chk("iss_rob_tag", iss_rob_tag, m_iss.rob_tag);
            chk("iss_a", iss_a, m_iss.a_val);
            chk("iss_b", iss_b, m_iss.b_val);
            chk("iss_ctrl", iss_ctrl, m_iss.ctrl);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        flush = 1'b0;
        disp_valid = 1'b0;
        cdb_valid = 1'b0;
    endtask

    task automatic dsp(input aluop_e op, input int tag, input logic ar, input int at, input logic [63:0] av,
                       input logic br, input int bt, input logic [63:0] bv);
        disp_valid = 1'b1;
        disp_ctrl.usign = 1'b0;
        disp_ctrl.aluop = op;
        disp_rob_tag = RobTag'(tag);
        disp_a_rdy = ar;
        disp_a_tag = RobTag'(at);
        disp_a_val = av;
        disp_b_rdy = br;
        disp_b_tag = RobTag'(bt);
        disp_b_val = bv;
    endtask

    task automatic cdb(input int t, input logic [63:0] v);
        cdb_valid = 1'b1;
        cdb_tag = RobTag'(t);
        cdb_val = v;
    endtask

    initial begin
        idle();
        dsp(ALU_ADD, 0, 1, 0, 0, 1, 0, 0);
        disp_valid = 1'b0;
        cdb_tag = '0;
        cdb_val = '0;
        iss_ready = 1'b1;
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        compare_all();
        chk("rst_iss_valid", iss_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_disp_ready", disp_ready, 1);
        chk("rst_iss_a", iss_a, 0);

        // Ready ADD 5+7 issues after two edges.
        dsp(ALU_ADD, 0, 1, 0, 5, 1, 0, 7);
        tick();
        idle();
        chk("t1_count_e0", count, 1);
        tick();
        chk("t1_valid", iss_valid, 1);
        chk("t1_a", iss_a, 5);
        chk("t1_b", iss_b, 7);
        chk("t1_op", iss_ctrl.aluop, ALU_ADD);
        chk("t1_count", count, 0);

        // Younger ready op overtakes an older op waiting on tag 9.
        dsp(ALU_SUB, 3, 0, 9, 64'hDEAD, 1, 0, 2);
        tick();
        dsp(ALU_OR, 4, 1, 0, 1, 1, 0, 1);
        tick();
        idle();
        tick();
        chk("t2_first_tag", iss_rob_tag, 4);
        chk("t2_count", count, 1);
        cdb(9, 64'h10);
        tick();
        idle();
        chk("t2_wake_gap", iss_valid, 0);
        tick();
        chk("t2_valid", iss_valid, 1);
        chk("t2_tag", iss_rob_tag, 3);
        chk("t2_a", iss_a, 64'h10);

        // Same-cycle CDB bypass into a dispatching op.
        dsp(ALU_XOR, 5, 1, 0, 3, 0, 2, 64'h1234);
        cdb(2, 64'hFF);
        tick();
        idle();
        chk("t3_count", count, 1);
        tick();
        chk("t3_valid", iss_valid, 1);
        chk("t3_b", iss_b, 64'hFF);
        chk("t3_tag", iss_rob_tag, 5);

        // Back-to-back ready ops issue oldest-first on consecutive cycles.
        for (int i = 0; i < 4; i++) begin
            dsp(ALU_ADD, i, 1, 0, i * 10, 1, 0, 1);
            tick();
            if (i > 0) begin
                chk("b2b_valid", iss_valid, 1);
                chk("b2b_tag", iss_rob_tag, i - 1);
            end
        end
        idle();
        tick();
        chk("b2b_last_tag", iss_rob_tag, 3);

        // Fill with pending ops while the issue register is stalled.
        tick();
        iss_ready = 1'b0;
        dsp(ALU_AND, 7, 1, 0, 64'h70, 1, 0, 1);
        tick();
        for (int i = 8; i < 12; i++) begin
            dsp(ALU_SLT, i, 0, 12, 0, 1, 0, 0);
            tick();
        end
        idle();
        chk("full_count", count, 4);
        chk("full_ready", disp_ready, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valid", iss_valid, 1);
            chk("hold_tag", iss_rob_tag, 7);
            chk("hold_a", iss_a, 64'h70);
            chk("hold_count", count, 4);
        end

        // Flush overrides dispatch and issue load.
        flush = 1'b1;
        tick();
        idle();
        dsp(ALU_ADD, 5, 1, 0, 1, 1, 0, 1);
        tick();
        for (int i = 1; i < 4; i++) begin
            dsp(ALU_SUB, i, 0, 12, 0, 1, 0, 0);
            tick();
        end
        idle();
        chk("pre_flush_count", count, 3);
        chk("pre_flush_valid", iss_valid, 1);
        flush = 1'b1;
        iss_ready = 1'b1;
        dsp(ALU_ADD, 9, 1, 0, 1, 1, 0, 1);
        tick();
        idle();
        chk("flush_count", count, 0);
        chk("flush_valid", iss_valid, 0);
        chk("flush_ready", disp_ready, 1);

        // Asynchronous reset in the middle of a wakeup.
        dsp(ALU_ADD, 2, 0, 1, 0, 1, 0, 0);
        tick();
        dsp(ALU_ADD, 6, 1, 0, 64'h66, 1, 0, 1);
        tick();
        idle();
        tick();
        chk("prerst_valid", iss_valid, 1);
        cdb(1, 64'h33);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", iss_valid, 0);
        chk("arst_count", count, 0);
        chk("arst_ready", disp_ready, 1);
        chk("arst_a", iss_a, 0);
        chk("arst_tag", iss_rob_tag, 0);
        chk("arst_ctrl", iss_ctrl, 0);
        model_reset();
        idle();
        @(negedge clk);
        reset = 1'b0;
        compare_all();

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            flush = ($urandom_range(0, 49) == 0);
            dsp(aluop_e'($urandom_range(0, 8)), $urandom_range(0, 15),
                $urandom_range(0, 1), $urandom_range(0, 3), {$urandom, $urandom},
                $urandom_range(0, 2) != 0, $urandom_range(0, 3), {$urandom, $urandom});
            disp_ctrl.usign = $urandom_range(0, 1);
            disp_valid = $urandom_range(0, 2) != 0;
            cdb_valid = $urandom_range(0, 2) == 0;
            cdb_tag = RobTag'($urandom_range(0, 3));
            cdb_val = {$urandom, $urandom};
            iss_ready = $urandom_range(0, 3) != 0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
